vram_arbiter: RTL and testbench

- Shares the single-port 16 KB video SRAM between the ULA video fetcher and the Z80 CPU path.
- Runs on clk28 with 4-cycle access slots, one slot per 7 MHz pixel clock; video reads have absolute priority.
- A CPU read or write is held pending until a free slot and completed with a one-cycle ack.
- Drives SRAM address, data and strobes directly, and returns read data to whichever requester owned the slot.

---
 rtl/vram_arb_pkg.sv | 8 +
 rtl/vram_cpu_req_latch.sv | 39 +++
 rtl/vram_arbiter.sv | 96 +++++++++
 tb/tb_vram_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: slot state encoding and slot phase numbers shared by the VRAM arbiter files
package vram_arb_pkg;
  typedef enum logic [1:0] {IDLE, VID_RD, CPU_RD, CPU_WR} state_e;
  localparam logic [1:0] PH_ARB = 2'd0;
  localparam logic [1:0] PH_STROBE_ON = 2'd1;
  localparam logic [1:0] PH_CAPTURE = 2'd2;
  localparam logic [1:0] PH_DONE = 2'd3;
endpackage

// File: rtl/vram_cpu_req_latch.sv
// vram_cpu_req_latch: holds one CPU request (we/addr/wdata) from cpu_req until ack_i; outputs pass live inputs through while empty
module vram_cpu_req_latch #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              ack_i,
  output logic              pend_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o
);
  logic              pend_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  always_ff @(posedge clk28 or negedge rst_n)
    if (!rst_n) begin
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (ack_i) begin
      pend_q <= 1'b0;
    end else if (!pend_q && cpu_req_i) begin
      pend_q  <= 1'b1;
      we_q    <= cpu_we_i;
      addr_q  <= cpu_addr_i;
      wdata_q <= cpu_wdata_i;
    end
  assign pend_o  = pend_q | cpu_req_i;
  assign we_o    = pend_q ? we_q : cpu_we_i;
  assign addr_o  = pend_q ? addr_q : cpu_addr_i;
  assign wdata_o = pend_q ? wdata_q : cpu_wdata_i;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: 4-phase slot arbiter of the video SRAM, video reads first, CPU access when free; drives SRAM pins, returns data and acks
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int WAIT_W = 8
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_miss,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [WAIT_W-1:0] cpu_stall_cnt,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  logic [1:0]        ph_q;
  state_e            state_q, arb, cur;
  logic              ph0, pend, lat_we, is_rd, is_cpu, is_wr;
  logic [ADDR_W-1:0] lat_addr, a_q, a_d;
  logic [DATA_W-1:0] lat_wdata, dout_q, dout_d, vid_data_q, cpu_rdata_q;
  logic              oe_n_q, we_n_q, dq_oe_q, vid_valid_q, cpu_ack_q, vid_miss_q;
  logic [WAIT_W-1:0] stall_q;
  vram_cpu_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_latch (
    .clk28(clk28), .rst_n(rst_n), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .ack_i(cpu_ack_q),
    .pend_o(pend), .we_o(lat_we), .addr_o(lat_addr), .wdata_o(lat_wdata)
  );
  // The slot owner is decided combinationally in ph0 so address and write data reach the pins in the slot's first cycle.
  always_comb begin
    ph0    = ph_q == PH_ARB;
    arb    = vid_req ? VID_RD : pend ? (lat_we ? CPU_WR : CPU_RD) : IDLE;
    cur    = ph0 ? arb : state_q;
    is_rd  = cur == VID_RD || cur == CPU_RD;
    is_wr  = cur == CPU_WR;
    is_cpu = cur == CPU_RD || is_wr;
    a_d    = (ph0 && cur != IDLE) ? (vid_req ? vid_addr : lat_addr) : a_q;
    dout_d = (ph0 && is_wr) ? lat_wdata : dout_q;
  end
  always_ff @(posedge clk28 or negedge rst_n)
    if (!rst_n) begin
      ph_q        <= PH_ARB;
      state_q     <= IDLE;
      a_q         <= '0;
      dout_q      <= '0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      vid_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      vid_miss_q  <= 1'b0;
      stall_q     <= '0;
    end else begin
      ph_q        <= ph_q + 2'd1;
      state_q     <= cur;
      a_q         <= a_d;
      dout_q      <= dout_d;
      oe_n_q      <= !(is_rd && ph_q != PH_DONE);
      we_n_q      <= !(is_wr && (ph0 || ph_q == PH_STROBE_ON));
      dq_oe_q     <= is_wr && ph_q != PH_DONE;
      vid_valid_q <= ph_q == PH_CAPTURE && cur == VID_RD;
      cpu_ack_q   <= ph_q == PH_CAPTURE && is_cpu;
      vid_miss_q  <= vid_miss_q | (vid_req & !ph0);
      if (ph_q == PH_CAPTURE && cur == VID_RD) vid_data_q <= sram_din;
      if (ph_q == PH_CAPTURE && cur == CPU_RD) cpu_rdata_q <= sram_din;
      if (ph0 && pend && vid_req && !(&stall_q)) stall_q <= stall_q + WAIT_W'(1);
    end
  assign sram_a        = a_d;
  assign sram_dout     = dout_d;
  assign sram_dq_oe    = dq_oe_q | (ph0 & is_wr);
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign vid_data      = vid_data_q;
  assign vid_valid     = vid_valid_q;
  assign vid_miss      = vid_miss_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_ack       = cpu_ack_q;
  assign cpu_wait      = pend & !is_cpu;
  assign cpu_stall_cnt = stall_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter with a behavioural 16 KB SRAM
module tb_vram_arbiter;
  logic        clk28 = 1'b0, rst_n = 1'b0;
  logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [13:0] vid_addr = '0, cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  vid_data, cpu_rdata, sram_dout, sram_din;
  logic        vid_valid, vid_miss, cpu_ack, cpu_wait, sram_dq_oe, sram_oe_n, sram_we_n;
  logic [7:0]  cpu_stall_cnt;
  logic [13:0] sram_a;
  logic [7:0]  mem [16384];
  logic [7:0]  vexp [4];
  int          total = 0, bad = 0;
  vram_arbiter dut (
    .clk28(clk28), .rst_n(rst_n), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_valid(vid_valid), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .cpu_stall_cnt(cpu_stall_cnt), .sram_a(sram_a), .sram_dout(sram_dout),
    .sram_dq_oe(sram_dq_oe), .sram_din(sram_din), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );
  always #5 clk28 = ~clk28;
  assign sram_din = mem[sram_a];
  always @(posedge clk28) if (!sram_we_n && sram_dq_oe) mem[sram_a] <= sram_dout;
  task automatic tick(input int n);
    repeat (n) @(posedge clk28);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 3 + 1);
    vexp[0] = 8'h01; vexp[1] = 8'h04; vexp[2] = 8'h07; vexp[3] = 8'h0A;
    tick(3);
    chk("rst_we_n", sram_we_n, 1); chk("rst_oe_n", sram_oe_n, 1); chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_ack", cpu_ack, 0); chk("rst_vvalid", vid_valid, 0); chk("rst_miss", vid_miss, 0);
    chk("rst_stall", cpu_stall_cnt, 0); chk("rst_wait", cpu_wait, 0); chk("rst_a", sram_a, 0);
    chk("rst_rdata", cpu_rdata, 0);
    rst_n = 1'b1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h1800; cpu_wdata = 8'h47; #1;
    chk("wr0_dq_oe", sram_dq_oe, 1); chk("wr0_a", sram_a, 14'h1800); chk("wr0_we_n", sram_we_n, 1);
    chk("wr0_wait", cpu_wait, 0); chk("wr0_dout", sram_dout, 8'h47);
    tick(1); cpu_req = 0; #1;
    chk("wr1_we_n", sram_we_n, 0); chk("wr1_dq_oe", sram_dq_oe, 1); chk("wr1_oe_n", sram_oe_n, 1);
    chk("wr1_wait", cpu_wait, 0);
    tick(1); chk("wr2_we_n", sram_we_n, 0); chk("wr2_ack", cpu_ack, 0);
    tick(1); chk("wr3_we_n", sram_we_n, 1); chk("wr3_ack", cpu_ack, 1); chk("wr3_dq_oe", sram_dq_oe, 1);
    tick(1); chk("wr_after_ack", cpu_ack, 0); chk("wr_after_dq_oe", sram_dq_oe, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h1800; #1;
    chk("rd0_oe_n", sram_oe_n, 1); chk("rd0_a", sram_a, 14'h1800);
    tick(1); cpu_req = 0; #1; chk("rd1_oe_n", sram_oe_n, 0);
    tick(2); chk("rd3_ack", cpu_ack, 1); chk("rd3_rdata", cpu_rdata, 8'h47);
    tick(1); chk("rd_after_ack", cpu_ack, 0); chk("rd_hold_rdata", cpu_rdata, 8'h47);
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0005;
    for (int k = 0; k < 4; k++) begin
      vid_req = 1; vid_addr = 14'(k); #1;
      chk("vs_wait_ph0", cpu_wait, 1); chk("vs_a_ph0", sram_a, 14'(k));
      tick(1); cpu_req = 0; vid_req = 0; vid_addr = 14'h3FFF; #1;
      chk("vs_oe_n", sram_oe_n, 0); chk("vs_a_held", sram_a, 14'(k));
      tick(2); chk("vs_valid", vid_valid, 1); chk("vs_data", vid_data, vexp[k]);
      chk("vs_wait_ph3", cpu_wait, 1); chk("vs_no_ack", cpu_ack, 0);
      tick(1);
    end
    chk("cpu_late_wait", cpu_wait, 0); chk("cpu_late_valid", vid_valid, 0);
    tick(3); chk("cpu_late_ack", cpu_ack, 1); chk("cpu_late_rdata", cpu_rdata, 8'h10);
    chk("stall4", cpu_stall_cnt, 4);
    tick(1);
    vid_req = 1; vid_addr = 14'h0002; cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0100; cpu_wdata = 8'h5A; #1;
    chk("both_wait", cpu_wait, 1); chk("both_dq_oe", sram_dq_oe, 0);
    tick(1); vid_req = 0; cpu_req = 0;
    tick(2); chk("both_vvalid", vid_valid, 1); chk("both_vdata", vid_data, 8'h07); chk("both_no_ack", cpu_ack, 0);
    tick(1); chk("both_cpu_dq_oe", sram_dq_oe, 1); chk("both_cpu_wait", cpu_wait, 0);
    tick(3); chk("both_ack", cpu_ack, 1); chk("stall5", cpu_stall_cnt, 5);
    tick(3); vid_req = 1; vid_addr = 14'h0001;
    tick(1); vid_req = 0; chk("miss_set", vid_miss, 1);
    tick(4); chk("miss_no_valid", vid_valid, 0); chk("miss_oe_n", sram_oe_n, 1); chk("miss_sticky", vid_miss, 1);
    tick(1);
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0100;
    tick(3); chk("hold1_ack", cpu_ack, 1); chk("hold1_rdata", cpu_rdata, 8'h5A);
    cpu_addr = 14'h0003;
    tick(1); chk("hold2_wait", cpu_wait, 0); chk("hold2_a", sram_a, 14'h0003); chk("hold2_no_ack", cpu_ack, 0);
    tick(3); chk("hold2_ack", cpu_ack, 1); chk("hold2_rdata", cpu_rdata, 8'h0A);
    cpu_req = 0;
    tick(1); chk("hold3_wait", cpu_wait, 0);
    tick(3); chk("hold3_no_ack", cpu_ack, 0);
    tick(1);
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0200; cpu_wdata = 8'h33;
    tick(1); cpu_req = 0; #1; chk("abort_we_low", sram_we_n, 0);
    rst_n = 0; #1;
    chk("abort_we_n", sram_we_n, 1); chk("abort_dq_oe", sram_dq_oe, 0); chk("abort_oe_n", sram_oe_n, 1);
    chk("abort_miss", vid_miss, 0); chk("abort_stall", cpu_stall_cnt, 0); chk("abort_wait", cpu_wait, 0);
    chk("abort_a", sram_a, 0); chk("abort_rdata", cpu_rdata, 0); chk("abort_vdata", vid_data, 0);
    chk("abort_dout", sram_dout, 0); chk("abort_ack", cpu_ack, 0);
    tick(2); rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      chk("post_no_ack", cpu_ack, 0); chk("post_we_n", sram_we_n, 1);
      tick(1);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0200;
    tick(1); cpu_req = 0;
    tick(2); chk("post_rd_ack", cpu_ack, 1); chk("post_rd_rdata", cpu_rdata, 8'h01);
    tick(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
